// File: rtl/serial_arith_pkg.sv
// Shared types and encodings for the bit-serial arithmetic datapath.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage : serial_arith_pkg

// File: rtl/full_adder_cell.sv
// Single-bit full adder; the only arithmetic cell in the serial datapath.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | ((a ^ b) & ci);

endmodule : full_adder_cell

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor: one result bit per clock, LSB first, via one full-adder cell.
module serial_adder_sub
   import serial_arith_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               carry_q, carry_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               cout_q, cout_d;
   logic               ovf_q, ovf_d;
   logic               s_bit;
   logic               c_next;

   full_adder_cell u_fa (
      .a  (a_q[0]),
      .b  (b_q[0]),
      .ci (carry_q),
      .s  (s_bit),
      .co (c_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   // Subtraction is a + ~b + 1, so the operand inversion and carry seed happen at accept time.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cout_d  = cout_q;
      ovf_d   = ovf_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = (sub == OP_ADD) ? b : ~b;
               carry_d = (sub == OP_ADD) ? cin : 1'b1;
               cnt_d   = '0;
               sum_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end else begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         SHIFT: begin
            sum_d   = {s_bit, sum_q[WIDTH-1:1]};
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = c_next;
            cnt_d   = cnt_q + CNT_W'(1);
            // MSB step: carry_q is the carry into the sign bit
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               cnt_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               cout_d  = c_next;
               ovf_d   = carry_q ^ c_next;
               state_d = DONE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule : serial_adder_sub

// File: tb/tb_serial_adder_sub.sv
// Directed self-checking bench for serial_adder_sub at WIDTH=8.
module tb_serial_adder_sub;

   localparam int unsigned WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             sub;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   serial_adder_sub #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   // Issue one operation from a negedge; return at the negedge where done is seen (or on timeout).
   task automatic run_op(input logic op_sub, input logic [7:0] op_a, input logic [7:0] op_b,
                         input logic op_cin, input int strobe_at,
                         output int edges, output int busy_cnt, output logic overlap);
      sub   = op_sub;
      a     = op_a;
      b     = op_b;
      cin   = op_cin;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      edges    = 1;
      busy_cnt = busy ? 1 : 0;
      overlap  = busy & done;
      while (!done && edges < 40) begin
         if (edges == strobe_at) begin
            start = 1'b1;
            a     = 8'hAA;
            b     = 8'h55;
            sub   = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         @(negedge clk);
         edges++;
         if (busy) busy_cnt++;
         if (busy && done) overlap = 1'b1;
      end
      start = 1'b0;
   endtask

   initial begin
      int   edges;
      int   bcnt;
      logic ovl;

      rst_n = 1'b0;
      start = 1'b0;
      sub   = 1'b0;
      cin   = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_sum",  32'(sum),  32'h0);

      // 0x5A + 0x33 + 1 = 0x8E, positive + positive -> negative
      run_op(1'b0, 8'h5A, 8'h33, 1'b1, 0, edges, bcnt, ovl);
      chk("add1_latency", 32'(edges), 32'd9);
      chk("add1_busy_cycles", 32'(bcnt), 32'd8);
      chk("add1_busy_done_overlap", 32'(ovl), 32'h0);
      chk("add1_sum",  32'(sum),  32'h8E);
      chk("add1_cout", 32'(cout), 32'h0);
      chk("add1_ovf",  32'(ovf),  32'h1);
      cycle(1);
      chk("add1_done_pulse", 32'(done), 32'h0);
      cycle(2);
      chk("idle_sum_hold", 32'(sum), 32'h8E);
      chk("idle_busy", 32'(busy), 32'h0);

      run_op(1'b0, 8'hFF, 8'h00, 1'b1, 0, edges, bcnt, ovl);
      chk("carry_sum",  32'(sum),  32'h00);
      chk("carry_cout", 32'(cout), 32'h1);
      chk("carry_ovf",  32'(ovf),  32'h0);
      cycle(1);

      run_op(1'b0, 8'h7F, 8'h01, 1'b0, 0, edges, bcnt, ovl);
      chk("pos_ovf_sum",  32'(sum),  32'h80);
      chk("pos_ovf_cout", 32'(cout), 32'h0);
      chk("pos_ovf_ovf",  32'(ovf),  32'h1);
      cycle(1);

      // cin must be ignored for subtraction
      run_op(1'b1, 8'h10, 8'h20, 1'b1, 0, edges, bcnt, ovl);
      chk("sub1_latency", 32'(edges), 32'd9);
      chk("sub1_sum",  32'(sum),  32'hF0);
      chk("sub1_cout", 32'(cout), 32'h0);
      chk("sub1_ovf",  32'(ovf),  32'h0);
      cycle(1);

      run_op(1'b1, 8'h80, 8'h01, 1'b0, 0, edges, bcnt, ovl);
      chk("sub2_sum",  32'(sum),  32'h7F);
      chk("sub2_cout", 32'(cout), 32'h1);
      chk("sub2_ovf",  32'(ovf),  32'h1);
      cycle(1);

      // Abort 0x5A+0x33+1 after three bits; partial sum is 0xC0 at that point
      sub   = 1'b0;
      a     = 8'h5A;
      b     = 8'h33;
      cin   = 1'b1;
      start = 1'b1;
      cycle(1);
      start = 1'b0;
      cycle(3);
      chk("pre_rst_partial_sum", 32'(sum), 32'hC0);
      chk("pre_rst_busy", 32'(busy), 32'h1);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("mid_rst_busy", 32'(busy), 32'h0);
      chk("mid_rst_done", 32'(done), 32'h0);
      chk("mid_rst_sum",  32'(sum),  32'h00);
      chk("mid_rst_cout", 32'(cout), 32'h0);
      chk("mid_rst_ovf",  32'(ovf),  32'h0);
      cycle(12);
      chk("post_rst_no_done", 32'(done), 32'h0);
      chk("post_rst_idle_busy", 32'(busy), 32'h0);

      // Start strobe during SHIFT with different operands must be ignored
      run_op(1'b0, 8'h12, 8'h34, 1'b0, 2, edges, bcnt, ovl);
      chk("ign_latency", 32'(edges), 32'd9);
      chk("ign_sum",  32'(sum),  32'h46);
      chk("ign_cout", 32'(cout), 32'h0);
      chk("ign_ovf",  32'(ovf),  32'h0);

      // Back-to-back: start held in the DONE cycle
      sub   = 1'b0;
      a     = 8'h01;
      b     = 8'h01;
      cin   = 1'b0;
      start = 1'b1;
      cycle(1);
      start = 1'b0;
      chk("b2b_busy", 32'(busy), 32'h1);
      chk("b2b_done", 32'(done), 32'h0);
      edges = 0;
      while (!done && edges < 40) begin
         cycle(1);
         edges++;
      end
      chk("b2b_latency", 32'(edges), 32'd8);
      chk("b2b_sum",  32'(sum),  32'h02);
      chk("b2b_cout", 32'(cout), 32'h0);
      cycle(3);
      chk("b2b_sum_hold", 32'(sum), 32'h02);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_serial_adder_sub
